// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//
// Shares one downstream memory bus between an instruction-fetch port (I) and
// a load/store data port (D). In IDLE the winning request is latched into the
// registered m_* fields. The arbiter stays busy until the memory returns both
// m_addr_ok and m_data_ok. The response is then routed back to the owner with a
// single-cycle combinational completion pulse.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   i_valid, i_addr      port-I request (held until i_data_ok)
//   i_addr_ok/i_data_ok  port-I completion pulse (identical)
//   i_data               32-bit instruction word selected by latched m_addr[2]
//   d_valid, d_addr, d_size, d_strobe, d_wdata
//                        port-D request (held until d_data_ok)
//   d_addr_ok/d_data_ok  port-D completion pulse (identical)
//   d_data               port-D read data (m_rdata pass-through)
//   m_valid, m_addr, m_size, m_strobe, m_wdata
//                        registered downstream request
//   m_addr_ok, m_data_ok, m_rdata
//                        downstream acknowledgement and read data
//   cnt_i, cnt_d         per-port completion counters (wrap)
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   undefined: D has fixed priority over I on simultaneous requests
//   defined:   on a conflict, the port not granted last wins

module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  // port I
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [31:0]         i_data,
  // port D
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_data,
  // downstream
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [2:0]          m_size,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata,
  // counters
  output logic [CNT_W-1:0]    cnt_i,
  output logic [CNT_W-1:0]    cnt_d
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state;
  logic   mem_done;
  logic   grant_d;

  // A transaction ends only when both handshakes are seen together.
  assign mem_done = m_addr_ok & m_data_ok;

  assign i_addr_ok = (state == BUSY_I) & mem_done;
  assign i_data_ok = i_addr_ok;
  assign d_addr_ok = (state == BUSY_D) & mem_done;
  assign d_data_ok = d_addr_ok;

  assign d_data = m_rdata;
  // Fetch word is picked with the latched address, not the live request.
  assign i_data = m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;  // 1 when D received the most recent grant

  assign grant_d = d_valid & (~i_valid | ~last_d);
`else
  assign grant_d = d_valid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      m_valid  <= 1'b0;
      m_addr   <= '0;
      m_size   <= '0;
      m_strobe <= '0;
      m_wdata  <= '0;
      cnt_i    <= '0;
      cnt_d    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= BUSY_D;
            m_valid  <= 1'b1;
            m_addr   <= d_addr;
            m_size   <= d_size;
            m_strobe <= d_strobe;
            m_wdata  <= d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            last_d   <= 1'b1;
`endif
          end else if (i_valid) begin
            state    <= BUSY_I;
            m_valid  <= 1'b1;
            m_addr   <= i_addr;
            m_size   <= 3'b010;
            m_strobe <= '0;
            m_wdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d   <= 1'b0;
`endif
          end
        end
        BUSY_I: begin
          if (mem_done) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            cnt_i   <= cnt_i + CNT_W'(1);
          end
        end
        BUSY_D: begin
          if (mem_done) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            cnt_d   <= cnt_d + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a per-cycle vector table plus
// hand-written sequences for repeated conflicts, mid-transaction reset and
// counter wrap (CNT_W = 4).

module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              i_valid;
  logic [63:0]       i_addr;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [31:0]       i_data;
  logic              d_valid;
  logic [63:0]       d_addr;
  logic [2:0]        d_size;
  logic [7:0]        d_strobe;
  logic [63:0]       d_wdata;
  logic              d_addr_ok;
  logic              d_data_ok;
  logic [63:0]       d_data;
  logic              m_valid;
  logic [63:0]       m_addr;
  logic [2:0]        m_size;
  logic [7:0]        m_strobe;
  logic [63:0]       m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [63:0]       m_rdata;
  logic [CNT_W-1:0]  cnt_i;
  logic [CNT_W-1:0]  cnt_d;

  int tests;
  int failed;

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_addr   (i_addr),
    .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok),
    .i_data   (i_data),
    .d_valid  (d_valid),
    .d_addr   (d_addr),
    .d_size   (d_size),
    .d_strobe (d_strobe),
    .d_wdata  (d_wdata),
    .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok),
    .d_data   (d_data),
    .m_valid  (m_valid),
    .m_addr   (m_addr),
    .m_size   (m_size),
    .m_strobe (m_strobe),
    .m_wdata  (m_wdata),
    .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok),
    .m_rdata  (m_rdata),
    .cnt_i    (cnt_i),
    .cnt_d    (cnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [63:0] ia;
    logic        dv;
    logic [63:0] da;
    logic [7:0]  ds;
    logic [63:0] dw;
    logic        mao;
    logic        mdo;
    logic [63:0] mr;
    logic        e_mv;
    logic [63:0] e_ma;
    logic [2:0]  e_msz;
    logic [7:0]  e_mst;
    logic [63:0] e_mw;
    logic        e_iok;
    logic        e_dok;
    logic [31:0] e_id;
    logic [3:0]  e_ci;
    logic [3:0]  e_cd;
  } vec_t;

  localparam logic [63:0] DW = 64'h0123_4567_89AB_CDEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_valid   = v.iv;
    i_addr    = v.ia;
    d_valid   = v.dv;
    d_addr    = v.da;
    d_strobe  = v.ds;
    d_wdata   = v.dw;
    m_addr_ok = v.mao;
    m_data_ok = v.mdo;
    m_rdata   = v.mr;
  endtask

  task automatic check_vec(input int n, input vec_t v);
    chk($sformatf("v%0d m_valid", n), 64'(m_valid), 64'(v.e_mv));
    chk($sformatf("v%0d m_addr", n), m_addr, v.e_ma);
    chk($sformatf("v%0d m_size", n), 64'(m_size), 64'(v.e_msz));
    chk($sformatf("v%0d m_strobe", n), 64'(m_strobe), 64'(v.e_mst));
    chk($sformatf("v%0d m_wdata", n), m_wdata, v.e_mw);
    chk($sformatf("v%0d i_data_ok", n), 64'(i_data_ok), 64'(v.e_iok));
    chk($sformatf("v%0d i_addr_ok", n), 64'(i_addr_ok), 64'(v.e_iok));
    chk($sformatf("v%0d d_data_ok", n), 64'(d_data_ok), 64'(v.e_dok));
    chk($sformatf("v%0d d_addr_ok", n), 64'(d_addr_ok), 64'(v.e_dok));
    if (v.e_iok) chk($sformatf("v%0d i_data", n), 64'(i_data), 64'(v.e_id));
    if (v.e_dok) chk($sformatf("v%0d d_data", n), d_data, v.mr);
    chk($sformatf("v%0d cnt_i", n), 64'(cnt_i), 64'(v.e_ci));
    chk($sformatf("v%0d cnt_d", n), 64'(cnt_d), 64'(v.e_cd));
  endtask

  // Sets every request/response input for one cycle (d_size is constant).
  task automatic set_in(input logic iv, input logic [63:0] ia, input logic dv,
                        input logic [63:0] da, input logic ok, input logic [63:0] mr);
    i_valid   = iv;
    i_addr    = ia;
    d_valid   = dv;
    d_addr    = da;
    d_strobe  = 8'h00;
    d_wdata   = 64'h0;
    m_addr_ok = ok;
    m_data_ok = ok;
    m_rdata   = mr;
  endtask

  vec_t vecs[12];

  initial begin
    tests  = 0;
    failed = 0;

    //              iv  ia             dv  da      ds     dw  mao mdo mr
    //              e_mv e_ma         e_msz e_mst e_mw iok dok e_id ci cd
    // single fetch, answered in the first m_valid cycle
    vecs[0]  = '{1'b1, 64'h8000_0004, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                 1'b0, 64'h0, 3'b000, 8'h00, 64'h0, 1'b0, 1'b0, 32'h0, 4'd0, 4'd0};
    vecs[1]  = '{1'b1, 64'h8000_0004, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 1'b1,
                 64'h1111_2222_3333_4444,
                 1'b1, 64'h8000_0004, 3'b010, 8'h00, 64'h0, 1'b1, 1'b0, 32'h1111_2222,
                 4'd0, 4'd0};
    vecs[2]  = '{1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                 1'b0, 64'h8000_0004, 3'b010, 8'h00, 64'h0, 1'b0, 1'b0, 32'h0, 4'd1, 4'd0};
    // conflict: D store wins, latency 3; d_addr changes and a partial handshake mid-way
    vecs[3]  = '{1'b1, 64'h1000, 1'b1, 64'h100, 8'hFF, DW, 1'b0, 1'b0, 64'h0,
                 1'b0, 64'h8000_0004, 3'b010, 8'h00, 64'h0, 1'b0, 1'b0, 32'h0, 4'd1, 4'd0};
    vecs[4]  = '{1'b1, 64'h1000, 1'b1, 64'h100, 8'hFF, DW, 1'b0, 1'b0, 64'h0,
                 1'b1, 64'h100, 3'b011, 8'hFF, DW, 1'b0, 1'b0, 32'h0, 4'd1, 4'd0};
    vecs[5]  = '{1'b1, 64'h1000, 1'b1, 64'h200, 8'hFF, DW, 1'b0, 1'b1, 64'h0,
                 1'b1, 64'h100, 3'b011, 8'hFF, DW, 1'b0, 1'b0, 32'h0, 4'd1, 4'd0};
    vecs[6]  = '{1'b1, 64'h1000, 1'b1, 64'h200, 8'hFF, DW, 1'b1, 1'b1,
                 64'h5555_6666_7777_8888,
                 1'b1, 64'h100, 3'b011, 8'hFF, DW, 1'b0, 1'b1, 32'h0, 4'd1, 4'd0};
    // waiting fetch is granted after the idle cycle; i_addr change ignored while busy
    vecs[7]  = '{1'b1, 64'h1000, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                 1'b0, 64'h100, 3'b011, 8'hFF, DW, 1'b0, 1'b0, 32'h0, 4'd1, 4'd1};
    vecs[8]  = '{1'b1, 64'h1000, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                 1'b1, 64'h1000, 3'b010, 8'h00, 64'h0, 1'b0, 1'b0, 32'h0, 4'd1, 4'd1};
    vecs[9]  = '{1'b1, 64'h2004, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                 1'b1, 64'h1000, 3'b010, 8'h00, 64'h0, 1'b0, 1'b0, 32'h0, 4'd1, 4'd1};
    vecs[10] = '{1'b1, 64'h2004, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 1'b1,
                 64'hAAAA_BBBB_CCCC_DDDD,
                 1'b1, 64'h1000, 3'b010, 8'h00, 64'h0, 1'b1, 1'b0, 32'hCCCC_DDDD,
                 4'd1, 4'd1};
    vecs[11] = '{1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0,
                 1'b0, 64'h1000, 3'b010, 8'h00, 64'h0, 1'b0, 1'b0, 32'h0, 4'd2, 4'd1};

    d_size = 3'b011;
    rst    = 1'b1;
    set_in(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset m_valid", 64'(m_valid), 64'h0);
    chk("reset m_addr", m_addr, 64'h0);
    chk("reset cnt_i", 64'(cnt_i), 64'h0);
    chk("reset cnt_d", 64'(cnt_d), 64'h0);
    rst = 1'b0;

    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      drive(vecs[n]);
      #1;
      check_vec(n, vecs[n]);
    end

    // Repeated conflict: D wins first; D's still-high valid then collides with
    // the waiting fetch again.
    @(negedge clk);
    set_in(1'b1, 64'h3000, 1'b1, 64'h300, 1'b0, 64'h0);
    #1 chk("c2 idle m_valid", 64'(m_valid), 64'h0);
    @(negedge clk);
    set_in(1'b1, 64'h3000, 1'b1, 64'h300, 1'b1, 64'h9);
    #1 chk("c2 first grant d_data_ok", 64'(d_data_ok), 64'h1);
    chk("c2 first grant m_addr", m_addr, 64'h300);
    @(negedge clk);
    set_in(1'b1, 64'h3000, 1'b1, 64'h300, 1'b0, 64'h0);
    #1 chk("c2 gap m_valid", 64'(m_valid), 64'h0);
    chk("c2 gap cnt_d", 64'(cnt_d), 64'd2);
    @(negedge clk);
    set_in(1'b1, 64'h3000, 1'b1, 64'h300, 1'b1, 64'h0000_0007_0000_0005);
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    chk("c2 second grant m_addr", m_addr, 64'h3000);
    chk("c2 second grant i_data_ok", 64'(i_data_ok), 64'h1);
    chk("c2 second grant i_data", 64'(i_data), 64'h5);
`else
    chk("c2 second grant m_addr", m_addr, 64'h300);
    chk("c2 second grant d_data_ok", 64'(d_data_ok), 64'h1);
`endif
    @(negedge clk);
    set_in(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    chk("c2 end cnt_i", 64'(cnt_i), 64'd3);
    chk("c2 end cnt_d", 64'(cnt_d), 64'd2);
`else
    chk("c2 end cnt_i", 64'(cnt_i), 64'd2);
    chk("c2 end cnt_d", 64'(cnt_d), 64'd3);
`endif

    // Reset while BUSY_I, then the held fetch is granted again.
    @(negedge clk);
    set_in(1'b1, 64'h4004, 1'b0, 64'h0, 1'b0, 64'h0);
    @(negedge clk);
    #1 chk("rst pre m_valid", 64'(m_valid), 64'h1);
    #1 rst = 1'b1;
    m_addr_ok = 1'b1;
    m_data_ok = 1'b1;
    #1 chk("rst mid m_valid", 64'(m_valid), 64'h0);
    chk("rst mid m_addr", m_addr, 64'h0);
    chk("rst mid i_data_ok", 64'(i_data_ok), 64'h0);
    chk("rst mid cnt_i", 64'(cnt_i), 64'h0);
    chk("rst mid cnt_d", 64'(cnt_d), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b1, 64'h4004, 1'b0, 64'h0, 1'b0, 64'h0);
    @(negedge clk);
    #1 chk("rst regrant m_valid", 64'(m_valid), 64'h1);
    chk("rst regrant m_addr", m_addr, 64'h4004);
    set_in(1'b1, 64'h4004, 1'b0, 64'h0, 1'b1, 64'h1234_5678_0000_0000);
    #1 chk("rst regrant i_data", 64'(i_data), 64'h1234_5678);
    @(negedge clk);
    set_in(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    #1 chk("rst regrant cnt_i", 64'(cnt_i), 64'd1);

    // 16 back-to-back D completions wrap the 4-bit counter to 0.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      set_in(1'b0, 64'h0, 1'b1, 64'h800, 1'b0, 64'h0);
      #1;
      if (k == 15) chk("wrap cnt_d at 15", 64'(cnt_d), 64'd15);
      @(negedge clk);
      set_in(1'b0, 64'h0, 1'b1, 64'h800, 1'b1, 64'h0);
      #1 chk($sformatf("wrap d_data_ok %0d", k), 64'(d_data_ok), 64'h1);
    end
    @(negedge clk);
    set_in(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    #1 chk("wrap cnt_d to 0", 64'(cnt_d), 64'd0);
    chk("wrap cnt_i unchanged", 64'(cnt_i), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
